reg_file_wr_arbiter: RTL and testbench

Write-port controller for the 32x32 register file in the multi-cycle core. It shares the register file's single write port between NUM_REQ requesters (requester 0 is core writeback, requester 1 is the debug/scan port) using round-robin arbitration with a valid/ready handshake. After every reset, and on `clear_req`, it sequences a zero-fill of registers 1..31 through the same port. It sits between the core control/debug logic and the `wen`/`waddr`/`wdata` inputs of the register file, and is the only block that drives them.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rr_grant.sv | 32 +++
 rtl/reg_file_wr_arbiter.sv | 104 ++++++++++
 tb/tb_reg_file_wr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write path.
package rf_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int NUM_REGS           = 1 << DEFAULT_ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int REQ_WB  = 0;
  localparam int REQ_DBG = 1;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: one-hot grant to the first valid requester
// after ptr (wrapping), plus the encoded index of that grant.
module rr_grant #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // The requester at ptr was served last, so it is checked last.
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Sole driver of the register-file write port: zero-fills registers 1..N-1
// after reset or clear_req, then round-robin arbitrates between requesters.
module reg_file_wr_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear_req,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rf_wen,
  output logic [ADDR_WIDTH-1:0]         rf_waddr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  output logic                          init_done,
  output logic                          dbg_state
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [IW-1:0]         PTR_INIT  = IW'(NUM_REQ - 1);

  rf_state_e             state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [IW-1:0]         rr_ptr;

  logic [NUM_REQ-1:0]    grant_raw;
  logic [IW-1:0]         grant_idx;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_grant #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_grant (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant_raw),
    .idx   (grant_idx)
  );

  // Handshake: a write is taken from requester i at a rising edge where
  // req_valid[i] & req_ready[i]. Ready never waits on anything downstream, and
  // a requester must hold valid/addr/data stable until it sees ready.
  assign req_ready = (state == RUN && !clear_req) ? grant_raw : '0;
  assign handshake = |req_ready;
  assign sel_addr  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data  = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign dbg_state = logic'(state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_addr  <= ADDR_WIDTH'(1);
      rr_ptr    <= PTR_INIT;
      rf_wen    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          // clear_req is deliberately ignored here; the fill always runs to the end.
          rf_wen   <= 1'b1;
          rf_waddr <= clr_addr;
          rf_wdata <= '0;
          if (clr_addr == LAST_ADDR) begin
            state     <= RUN;
            init_done <= 1'b1;
            clr_addr  <= ADDR_WIDTH'(1);
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state     <= CLEAR;
            init_done <= 1'b0;
            clr_addr  <= ADDR_WIDTH'(1);
            rf_wen    <= 1'b0;
          end else if (handshake) begin
            // Address 0 is hardwired zero: accept the request but suppress the write.
            rf_wen   <= (sel_addr != '0);
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
            rr_ptr   <= grant_idx;
          end else begin
            rf_wen <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed plus randomized bench for reg_file_wr_arbiter against a cycle-level
// behavioural model of the fill sequence and round-robin write port.
module tb_reg_file_wr_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             clear_req = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*AW-1:0] req_addr  = '0;
  logic [NR*DW-1:0] req_data  = '0;
  logic [NR-1:0]    req_ready;
  logic             rf_wen;
  logic [AW-1:0]    rf_waddr;
  logic [DW-1:0]    rf_wdata;
  logic             init_done;
  logic             dbg_state;

  reg_file_wr_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REQ    (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [AW+DW-1:0] exp_q[$];

  bit            m_run;
  int            m_fill;
  int            m_ptr;
  logic          exp_wen;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;
  logic          exp_done;
  logic [NR-1:0] last_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester that would be served now, or -1.
  function automatic int model_pick();
    if (!m_run || clear_req) return -1;
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_run     = 1'b0;
    m_fill    = 1;
    m_ptr     = NR - 1;
    exp_wen   = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_done  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    int g;
    g = model_pick();
    if (!m_run) begin
      exp_wen   = 1'b1;
      exp_waddr = AW'(m_fill);
      exp_wdata = '0;
      exp_q.push_back({exp_waddr, exp_wdata});
      if (m_fill == (1 << AW) - 1) begin
        m_run    = 1'b1;
        exp_done = 1'b1;
        m_fill   = 1;
      end else begin
        m_fill++;
      end
    end else if (clear_req) begin
      m_run    = 1'b0;
      exp_done = 1'b0;
      m_fill   = 1;
      exp_wen  = 1'b0;
    end else if (g >= 0) begin
      exp_waddr = req_addr[g*AW +: AW];
      exp_wdata = req_data[g*DW +: DW];
      exp_wen   = (exp_waddr != 0);
      if (exp_wen) exp_q.push_back({exp_waddr, exp_wdata});
      m_ptr = g;
    end else begin
      exp_wen = 1'b0;
    end
  endtask

  // One clock: check combinational outputs at negedge, registered ones after the edge.
  task automatic tick();
    int g;
    logic [NR-1:0] er;
    logic [AW+DW-1:0] w;
    @(negedge clk);
    g  = model_pick();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    last_ready = req_ready;
    check("req_ready", req_ready, er);
    check("init_done", init_done, exp_done);
    check("dbg_state", dbg_state, m_run);
    @(posedge clk);
    model_edge();
    #1;
    check("rf_wen", rf_wen, exp_wen);
    check("rf_waddr", rf_waddr, exp_waddr);
    check("rf_wdata", rf_wdata, exp_wdata);
    if (rf_wen === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected_write observed=%0h expected=none", {rf_waddr, rf_wdata});
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("sb_write", {rf_waddr, rf_wdata}, w);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic idle();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    clear_req = 1'b0;
  endtask

  // Asserts reset away from the clock edge and checks outputs clear immediately.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    #1;
    model_reset();
    check("rst_wen", rf_wen, 1'b0);
    check("rst_waddr", rf_waddr, '0);
    check("rst_wdata", rf_wdata, '0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_ready", req_ready, '0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    last_ready = '0;

    // Reset fill: 31 zero writes to 1..31, ready low, init_done with the last.
    apply_reset();
    tick();
    check("fill_first_addr", rf_waddr, 5'd1);
    repeat (30) tick();
    check("fill_last_addr", rf_waddr, 5'd31);
    check("fill_done", init_done, 1'b1);

    // Single request on requester 0.
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check("single_ready", last_ready, 2'b01);
    idle();
    check("single_wen", rf_wen, 1'b1);
    check("single_waddr", rf_waddr, 5'd5);
    check("single_wdata", rf_wdata, 32'hDEADBEEF);
    tick();
    check("single_wen_drop", rf_wen, 1'b0);

    // Contention right after reset: grants alternate starting with requester 0.
    apply_reset();
    repeat (31) tick();
    set_req(0, 1'b1, 5'd3, 32'h11);
    set_req(1, 1'b1, 5'd4, 32'h22);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("cont_grant", last_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("cont_waddr", rf_waddr, (k % 2 == 0) ? 5'd3 : 5'd4);
      check("cont_wdata", rf_wdata, (k % 2 == 0) ? 32'h11 : 32'h22);
    end
    idle();
    tick();

    // Write to address 0 is accepted but produces no write enable.
    set_req(1, 1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    check("a0_ready", last_ready, 2'b10);
    check("a0_wen", rf_wen, 1'b0);
    idle();
    tick();

    // clear_req in RUN with a pending request; clear_req in CLEAR is ignored.
    set_req(0, 1'b1, 5'd7, 32'h77);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr_ready", last_ready, 2'b00);
    check("clr_init_done", init_done, 1'b0);
    repeat (5) tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (25) tick();
    check("clr_fill_end", rf_waddr, 5'd31);
    tick();
    check("clr_first_grant", last_ready, 2'b01);
    check("clr_waddr", rf_waddr, 5'd7);
    check("clr_wdata", rf_wdata, 32'h77);
    idle();
    tick();

    // Reset in the middle of a clear sequence restarts the fill at 1.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (12) tick();
    check("midclr_addr", rf_waddr, 5'd12);
    apply_reset();
    tick();
    check("midclr_restart", rf_waddr, 5'd1);
    repeat (30) tick();

    // Randomized traffic with occasional clear pulses.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || last_ready[i]) begin
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
        end
      end
      clear_req = ($urandom_range(0, 49) == 0);
      tick();
    end
    idle();
    repeat (2) tick();

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL sb_missing_writes observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
